// File: rtl/ok_pipe_pkg.sv
// Shared definitions for the block-throttled pipe-out source.
//   WORD_W       : width of one pipe word
//   pipe_state_e : transfer-control FSM states
package ok_pipe_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        XFER  = 2'd2
    } pipe_state_e;

endpackage : ok_pipe_pkg

// File: rtl/ok_sync_fifo.sv
// Synchronous single-clock FIFO with registered read data and exact fill count.
// Sole owner of the read/write pointers, which wrap modulo 2^DEPTH_LOG2.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write wr_data_i (ignored when full)
//   wr_data_i    : write word
//   pop_i        : read head word into rd_data_o next cycle (ignored when empty)
//   rd_zero_i    : force rd_data_o to zero next cycle (when no pop happens)
//   rd_data_o    : registered read data, held between pops
//   count_o      : registered number of stored words
//   wr_ready_o   : registered "space available"; low while in reset
//   empty_o      : registered "no words stored"
module ok_sync_fifo
    import ok_pipe_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WORD_W-1:0]     wr_data_i,
    input  logic                  pop_i,
    input  logic                  rd_zero_i,
    output logic [WORD_W-1:0]     rd_data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  wr_ready_o,
    output logic                  empty_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [WORD_W-1:0]     rd_data_q;
    logic                  wr_ready_q;
    logic                  empty_q;
    logic                  push_ok;
    logic                  pop_ok;

    // Qualify requests against the current occupancy so the count can never wrap.
    always_comb begin
        push_ok = push_i && (count_q != DEPTH_CNT);
        pop_ok  = pop_i && (count_q != '0);
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage array; contents are don't-care after reset because pointers restart.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, count, status flags and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            wr_ready_q <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end else if (rd_zero_i) begin
                rd_data_q <= '0;
            end
            count_q    <= count_d;
            wr_ready_q <= (count_d != DEPTH_CNT);
            empty_q    <= (count_d == '0);
        end
    end

    assign rd_data_o  = rd_data_q;
    assign count_o    = count_q;
    assign wr_ready_o = wr_ready_q;
    assign empty_o    = empty_q;

endmodule : ok_sync_fifo

// File: rtl/ok_btpipe_out_source.sv
// Block-throttled pipe-out source: buffers user words and releases them to a
// pipe-out endpoint one full block at a time.
// Ports:
//   ti_clk, rst_n     : clock, asynchronous active-low reset
//   src_valid/src_data/src_ready : user word handshake (accept when both high)
//   ep_read           : endpoint requests one word (data appears next cycle)
//   ep_blockstrobe    : endpoint starts one block
//   ep_datain         : word returned to the endpoint (0x0000 after a bad read)
//   ep_ready          : a full block is buffered and armed
//   fill_count        : words currently buffered
//   underrun          : sticky protocol-error flag, cleared only by reset
module ok_btpipe_out_source
    import ok_pipe_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS = 256,
    parameter int unsigned DEPTH_LOG2  = 10
)
(
    input  logic                  ti_clk,
    input  logic                  rst_n,
    input  logic                  src_valid,
    input  logic [WORD_W-1:0]     src_data,
    output logic                  src_ready,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [WORD_W-1:0]     ep_datain,
    output logic                  ep_ready,
    output logic [DEPTH_LOG2:0]   fill_count,
    output logic                  underrun
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    pipe_state_e        state_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic               ep_ready_q;
    logic               underrun_q;

    logic               fifo_wr_ready;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [WORD_W-1:0]  fifo_rd_data;

    logic               push;
    logic               pop;
    logic               bad_read;
    logic               bad_strobe;

    // Handshake qualification and protocol-error detection.
    always_comb begin
        push       = src_valid && fifo_wr_ready;
        pop        = ep_read && (state_q == XFER) && !fifo_empty;
        bad_read   = ep_read && !pop;
        bad_strobe = ep_blockstrobe && (state_q != ARMED);
    end

    ok_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (ti_clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .wr_data_i  (src_data),
        .pop_i      (pop),
        .rd_zero_i  (bad_read),
        .rd_data_o  (fifo_rd_data),
        .count_o    (fifo_count),
        .wr_ready_o (fifo_wr_ready),
        .empty_o    (fifo_empty)
    );

    // Transfer FSM; ep_ready is updated together with every state change so it
    // is high exactly while the FSM sits in ARMED.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            ep_ready_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (bad_read || bad_strobe) begin
                underrun_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (fifo_count >= BLOCK_CNT) begin
                        state_q    <= ARMED;
                        ep_ready_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (ep_blockstrobe) begin
                        state_q    <= XFER;
                        ep_ready_q <= 1'b0;
                        word_cnt_q <= '0;
                    end
                end
                XFER: begin
                    if (pop) begin
                        word_cnt_q <= word_cnt_q + CNT_W'(1);
                        if (word_cnt_q == LAST_WORD) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ep_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready  = fifo_wr_ready;
    assign ep_datain  = fifo_rd_data;
    assign ep_ready   = ep_ready_q;
    assign fill_count = fifo_count;
    assign underrun   = underrun_q;

endmodule : ok_btpipe_out_source

// File: tb/tb_ok_btpipe_out_source.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed literal expectations, plus a small-depth instance for wrap checks.
module tb_ok_btpipe_out_source;

    localparam int BW    = 256;
    localparam int DL    = 10;
    localparam int DEPTH = 1024;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        src_valid = 1'b0;
    logic [15:0] src_data  = 16'h0;
    logic        ep_read   = 1'b0;
    logic        ep_blockstrobe = 1'b0;
    logic        src_ready;
    logic [15:0] ep_datain;
    logic        ep_ready;
    logic [DL:0] fill_count;
    logic        underrun;

    logic        src_valid2 = 1'b0;
    logic [15:0] src_data2  = 16'h0;
    logic        ep_read2   = 1'b0;
    logic        ep_blockstrobe2 = 1'b0;
    logic        src_ready2;
    logic [15:0] ep_datain2;
    logic        ep_ready2;
    logic [4:0]  fill_count2;
    logic        underrun2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ok_btpipe_out_source #(.BLOCK_WORDS(BW), .DEPTH_LOG2(DL)) dut (
        .ti_clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .ep_read(ep_read), .ep_blockstrobe(ep_blockstrobe),
        .ep_datain(ep_datain), .ep_ready(ep_ready), .fill_count(fill_count),
        .underrun(underrun)
    );

    ok_btpipe_out_source #(.BLOCK_WORDS(4), .DEPTH_LOG2(4)) dut2 (
        .ti_clk(clk), .rst_n(rst_n), .src_valid(src_valid2), .src_data(src_data2),
        .src_ready(src_ready2), .ep_read(ep_read2), .ep_blockstrobe(ep_blockstrobe2),
        .ep_datain(ep_datain2), .ep_ready(ep_ready2), .fill_count(fill_count2),
        .underrun(underrun2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the block-transfer mode.
    logic [15:0] mq[$];
    int          m_mode  = 0;   // 0 idle, 1 armed, 2 transferring
    int          m_cnt   = 0;
    logic [15:0] m_dout  = 16'h0;
    logic        m_under = 1'b0;
    logic        m_rdy   = 1'b0;
    logic        m_srdy  = 1'b0;

    task automatic model_step();
        int   sz;
        logic do_push;
        logic do_pop;
        sz      = mq.size();
        do_push = src_valid && m_srdy;
        do_pop  = ep_read && (m_mode == 2) && (sz > 0);
        if (ep_read && !do_pop) begin
            m_dout  = 16'h0;
            m_under = 1'b1;
        end
        if (do_pop) m_dout = mq.pop_front();
        if (ep_blockstrobe && (m_mode != 1)) m_under = 1'b1;
        if (m_mode == 0) begin
            if (sz >= BW) m_mode = 1;
        end else if (m_mode == 1) begin
            if (ep_blockstrobe) begin
                m_mode = 2;
                m_cnt  = 0;
            end
        end else if (do_pop) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == BW) m_mode = 0;
        end
        if (do_push) mq.push_back(src_data);
        m_rdy  = (m_mode == 1);
        m_srdy = (mq.size() < DEPTH);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_mode = 0; m_cnt = 0; m_dout = 16'h0;
                m_under = 1'b0; m_rdy = 1'b0; m_srdy = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_ep_ready",   32'(ep_ready),   32'(m_rdy));
            chk("m_ep_datain",  32'(ep_datain),  32'(m_dout));
            chk("m_src_ready",  32'(src_ready),  32'(m_srdy));
            chk("m_fill_count", 32'(fill_count), 32'(mq.size()));
            chk("m_underrun",   32'(underrun),   32'(m_under));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            src_valid = 1'b1;
            src_data  = 16'(base + i);
        end
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ep_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(ep_ready), 32'd1);
    endtask

    task automatic strobe();
        ep_blockstrobe = 1'b1;
        @(negedge clk);
        ep_blockstrobe = 1'b0;
    endtask

    task automatic read_words(input int n);
        for (int i = 0; i < n; i++) begin
            ep_read = 1'b1;
            @(negedge clk);
        end
        ep_read = 1'b0;
    endtask

    task automatic run_small_depth();
        logic [15:0] sb2[$];
        logic [15:0] nxt;
        int          cyc;
        int          n;
        nxt = 16'h1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            src_valid2 = 1'b1; src_data2 = nxt; sb2.push_back(nxt); nxt++;
        end
        @(negedge clk);
        src_valid2 = 1'b0;
        chk("w_fill_pre", 32'(fill_count2), 32'd8);
        cyc = 0;
        while (cyc < 500) begin
            n = 0;
            while (ep_ready2 !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++; cyc++;
                chk("w_fill_gap", 32'(fill_count2), 32'd8);
            end
            chk("w_ready", 32'(ep_ready2), 32'd1);
            if (ep_ready2 !== 1'b1) break;
            ep_blockstrobe2 = 1'b1;
            @(negedge clk);
            ep_blockstrobe2 = 1'b0;
            cyc++;
            for (int k = 0; k < 4; k++) begin
                ep_read2 = 1'b1; src_valid2 = 1'b1; src_data2 = nxt;
                sb2.push_back(nxt); nxt++;
                @(negedge clk);
                cyc++;
                chk("w_data", 32'(ep_datain2), 32'(sb2.pop_front()));
                chk("w_fill", 32'(fill_count2), 32'd8);
            end
            ep_read2 = 1'b0; src_valid2 = 1'b0;
        end
        chk("w_underrun", 32'(underrun2), 32'd0);
    endtask

    initial begin
        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        chk("rst_ep_ready",  32'(ep_ready),   32'd0);
        chk("rst_ep_datain", 32'(ep_datain),  32'd0);
        chk("rst_underrun",  32'(underrun),   32'd0);
        chk("rst_src_ready", 32'(src_ready),  32'd0);
        chk("rst_fill",      32'(fill_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_src_ready", 32'(src_ready), 32'd1);

        // 255 words: not yet a block.
        push_words(255, 0);
        repeat (3) begin
            @(negedge clk);
            chk("b255_ep_ready", 32'(ep_ready), 32'd0);
        end
        // 256th word: ep_ready two cycles after it is offered.
        src_valid = 1'b1; src_data = 16'h00FF;
        @(negedge clk);
        src_valid = 1'b0;
        chk("b256_ready_c1", 32'(ep_ready), 32'd0);
        @(negedge clk);
        chk("b256_ready_c2", 32'(ep_ready), 32'd1);
        strobe();
        chk("strobe_ready_low", 32'(ep_ready), 32'd0);
        for (int i = 0; i < 256; i++) begin
            ep_read = 1'b1;
            @(negedge clk);
            chk("blk_data", 32'(ep_datain), 32'(i));
        end
        ep_read = 1'b0;
        chk("blk_underrun", 32'(underrun),   32'd0);
        chk("blk_fill",     32'(fill_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("blk_idle_ready", 32'(ep_ready),  32'd0);
        chk("blk_hold_data",  32'(ep_datain), 32'h00FF);

        // Read in IDLE: zero data, sticky underrun survives a good block.
        ep_read = 1'b1;
        @(negedge clk);
        ep_read = 1'b0;
        chk("idle_rd_data",     32'(ep_datain), 32'd0);
        chk("idle_rd_underrun", 32'(underrun),  32'd1);
        push_words(256, 16'h0100);
        wait_ready("b2_ready");
        strobe();
        read_words(1);
        chk("b2_first_data", 32'(ep_datain), 32'h0100);
        read_words(255);
        chk("b2_last_data", 32'(ep_datain), 32'h01FF);
        chk("b2_underrun",  32'(underrun),  32'd1);

        // Fill to full: back-pressure, then one pop re-opens the input.
        do_reset();
        push_words(1024, 0);
        chk("full_fill",      32'(fill_count), 32'd1024);
        chk("full_src_ready", 32'(src_ready),  32'd0);
        src_valid = 1'b1; src_data = 16'hDEAD;
        repeat (4) begin
            @(negedge clk);
            chk("full_hold_fill", 32'(fill_count), 32'd1024);
            chk("full_hold_rdy",  32'(src_ready),  32'd0);
        end
        src_valid = 1'b0;
        wait_ready("full_ready");
        strobe();
        read_words(1);
        chk("pop_src_ready", 32'(src_ready),  32'd1);
        chk("pop_fill",      32'(fill_count), 32'd1023);
        chk("pop_data",      32'(ep_datain),  32'd0);

        // Asynchronous reset at the 100th word of a transfer.
        do_reset();
        push_words(256, 16'h2000);
        wait_ready("ar_ready");
        strobe();
        read_words(99);
        chk("ar_data99", 32'(ep_datain), 32'h2062);
        ep_read = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ep_ready",  32'(ep_ready),   32'd0);
        chk("ar_ep_datain", 32'(ep_datain),  32'd0);
        chk("ar_underrun",  32'(underrun),   32'd0);
        chk("ar_src_ready", 32'(src_ready),  32'd0);
        chk("ar_fill",      32'(fill_count), 32'd0);
        ep_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_post_fill",  32'(fill_count), 32'd0);
        chk("ar_post_ready", 32'(ep_ready),   32'd0);

        // Small-depth instance: sustained push+pop with pointer wrap.
        run_small_depth();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ok_btpipe_out_source
